program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//  Program counter and next-address logic for the 8-bit microprocessor.
//  Drives pm_addr into the program ROM, whose output next_instr loads the
//  instruction decoder's ir.
//  Consumes the decoder's jmp/jmp_nz/ir_nibble and the computational unit's
//  zero flag (dont_jmp).
//  Adds a hold (stall) input and a small return-address stack for call/ret.
// PARAMETERS
//  ADDR_W      8      program memory address width
//  STACK_DEPTH 4      return-address stack entries (2..8)
//  RESET_ADDR  8'h00  address fetched after reset
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  reset        in   1       asynchronous, active-high reset
//  jmp          in   1       unconditional jump (decoder)
//  jmp_nz       in   1       conditional jump, taken when dont_jmp==0
//  dont_jmp     in   1       zero flag from computational unit
//  call         in   1       push return address, jump to target
//  ret          in   1       pop return address, jump to it
//  hold         in   1       stall: pc and stack frozen
//  ir_nibble    in   4       low nibble of jump/call target
//  pm_addr      out  ADDR_W  next fetch address (combinational)
//  pc           out  ADDR_W  registered current address
//  stack_depth  out  3       number of valid stack entries
//  stack_err    out  1       sticky over/underflow flag
//  from_PS      out  8       debug: count of taken branches (jmp/jmp_nz/call/ret)
// BEHAVIOUR
//  - Reset: pc=RESET_ADDR, stack_depth=0, stack_err=0, from_PS=0, all
//    stack entries 0. While reset is high, pm_addr=RESET_ADDR.
//  - pc <= pm_addr every clk rising edge when not in reset.
//  - target = {pc[ADDR_W-1:4], ir_nibble} (page-relative, 16-word pages).
//  - pm_addr priority (highest first):
//      hold                  -> pc (stack, from_PS unchanged)
//      ret                   -> top of stack (pop); if empty -> pc+1
//      call                  -> target; push pc+1
//      jmp                   -> target
//      jmp_nz & !dont_jmp    -> target
//      jmp_nz & dont_jmp     -> pc+1
//      otherwise             -> pc+1
//  - pc+1 wraps modulo 2^ADDR_W (8'hFF -> 8'h00); the carry is discarded.
//  - Stack is LIFO and updates on the same edge that loads pc.
//    Push when full: entry dropped, jump still taken, stack_err<=1.
//    Pop when empty: falls through to pc+1, stack_err<=1.
//  - stack_err is sticky and cleared only by reset.
//  - call and ret together: ret wins, call ignored, no error.
//  - from_PS increments by 1 per taken jmp/jmp_nz/call/successful ret.
//    Underflowed ret does not count. Wraps 8'hFF -> 8'h00.
//  - Latency: a branch input seen in cycle n appears on pm_addr in cycle n
//    (combinational) and on pc after edge n.
//  - Reset asserted mid-operation: all state cleared immediately (async).
//    The first fetch after deassertion is RESET_ADDR.
// TESTING
//  1. Reset, then 20 idle clocks -> pc steps 00..13, pm_addr = pc+1, from_PS=0.
//  2. pc=8'h37, jmp=1, ir_nibble=4'hA -> pm_addr=8'h3A, pc=8'h3A next edge,
//     from_PS=1.
//  3. pc=8'h50, jmp_nz=1: dont_jmp=1 -> pc=8'h51; with dont_jmp=0 and
//     ir_nibble=2 -> pc=8'h52.
//  4. call at pc=8'h20 (nibble 8) -> pc=8'h28, depth=1; ret -> pc=8'h21,
//     depth=0.
//  5. Five nested calls with STACK_DEPTH=4 -> depth stays 4, stack_err=1.
//     Then five rets -> the 5th falls through to pc+1.
//  6. hold=1 for 3 cycles during a jmp -> pc frozen. Then pc=8'hFF with no
//     branch -> pc=8'h00. Async reset mid-cycle -> pc=00 without a clock edge.

Source files
------------

// File: rtl/program_sequencer.sv
// Program counter and next-address logic with stall input and a small
// return-address stack for call/ret.
module program_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jmp,
  input  logic              jmp_nz,
  input  logic              dont_jmp,
  input  logic              call,
  input  logic              ret,
  input  logic              hold,
  input  logic [3:0]        ir_nibble,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        stack_depth,
  output logic              stack_err,
  output logic [7:0]        from_PS
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_POP,
    SEL_UNDER,
    SEL_CALL,
    SEL_JMP
  } sel_t;

  sel_t              sel;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0]  depth_q;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              stack_empty;
  logic              stack_full;
  logic              push;
  logic              pop;
  logic              stack_fault;
  logic              taken;

  assign pc_inc      = pc + ADDR_W'(1);
  assign target      = {pc[ADDR_W-1:4], ir_nibble};
  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == CNT_W'(STACK_DEPTH));
  assign push_idx    = IDX_W'(depth_q);
  assign top_idx     = IDX_W'(depth_q - CNT_W'(1));

  // Branch selection: hold beats ret, ret beats call, then jumps.
  always_comb begin
    sel = SEL_SEQ;
    if (hold) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      sel = stack_empty ? SEL_UNDER : SEL_POP;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (jmp) begin
      sel = SEL_JMP;
    end else if (jmp_nz && !dont_jmp) begin
      sel = SEL_JMP;
    end
  end

  always_comb begin
    next_addr = pc_inc;
    case (sel)
      SEL_HOLD:          next_addr = pc;
      SEL_POP:           next_addr = stack_mem[top_idx];
      SEL_CALL, SEL_JMP: next_addr = target;
      default:           next_addr = pc_inc;
    endcase
  end

  assign pm_addr     = reset ? RESET_ADDR : next_addr;
  assign push        = (sel == SEL_CALL) && !stack_full;
  assign pop         = (sel == SEL_POP);
  assign stack_fault = ((sel == SEL_CALL) && stack_full) || (sel == SEL_UNDER);
  assign taken       = (sel == SEL_CALL) || (sel == SEL_JMP) || (sel == SEL_POP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_ADDR;
    end else begin
      pc <= next_addr;
    end
  end

  // A push onto a full stack drops the return address; the call still jumps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
      depth_q <= '0;
    end else if (push) begin
      stack_mem[push_idx] <= pc_inc;
      depth_q             <= depth_q + CNT_W'(1);
    end else if (pop) begin
      depth_q <= depth_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stack_err <= 1'b0;
    end else if (stack_fault) begin
      stack_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      from_PS <= 8'd0;
    end else if (taken) begin
      from_PS <= from_PS + 8'd1;
    end
  end

  // An 8-entry stack cannot report 8 on a 3-bit port, so the count saturates.
  if (CNT_W > 3) begin : g_depth_sat
    assign stack_depth = (depth_q > CNT_W'(7)) ? 3'd7 : depth_q[2:0];
  end else begin : g_depth_direct
    assign stack_depth = 3'(depth_q);
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: reset checks, a constant vector table, the
// multi-cycle corner sequences, and random stimulus against a queue model.
module tb_program_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       jmp, jmp_nz, dont_jmp, call, ret, hold;
  logic [3:0] ir_nibble;
  logic [7:0] pm_addr, pc, from_PS;
  logic [2:0] stack_depth;
  logic       stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  program_sequencer #(.ADDR_W(8), .STACK_DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .dont_jmp   (dont_jmp),
    .call       (call),
    .ret        (ret),
    .hold       (hold),
    .ir_nibble  (ir_nibble),
    .pm_addr    (pm_addr),
    .pc         (pc),
    .stack_depth(stack_depth),
    .stack_err  (stack_err),
    .from_PS    (from_PS)
  );

  // ctl bit order: {jmp, jmp_nz, dont_jmp, call, ret, hold}
  typedef struct {
    logic [5:0] ctl;
    logic [3:0] nib;
    logic [7:0] pm;
    logic [7:0] pc;
    logic [2:0] depth;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_JMP  = 6'b100000;
  localparam logic [5:0] C_JNZ  = 6'b010000;
  localparam logic [5:0] C_DONT = 6'b001000;
  localparam logic [5:0] C_CALL = 6'b000100;
  localparam logic [5:0] C_RET  = 6'b000010;
  localparam logic [5:0] C_HOLD = 6'b000001;

  // Reference model: pc, counter, error flag, and the stack as a queue.
  logic [7:0] m_pc, m_cnt, m_next;
  logic       m_err;
  logic [7:0] m_stack[$];
  bit         m_push, m_pop, m_bad, m_taken;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_pc  = 8'h00;
    m_cnt = 8'h00;
    m_err = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_predict(input logic [5:0] ctl, input logic [3:0] nib);
    logic [7:0] seq;
    logic [7:0] tgt;
    seq     = m_pc + 8'd1;
    tgt     = {m_pc[7:4], nib};
    m_push  = 0;
    m_pop   = 0;
    m_bad   = 0;
    m_taken = 0;
    if (ctl[0]) begin
      m_next = m_pc;
    end else if (ctl[1]) begin
      if (m_stack.size() > 0) begin
        m_next  = m_stack[$];
        m_pop   = 1;
        m_taken = 1;
      end else begin
        m_next = seq;
        m_bad  = 1;
      end
    end else if (ctl[2]) begin
      m_next  = tgt;
      m_taken = 1;
      if (m_stack.size() < DEPTH) m_push = 1;
      else m_bad = 1;
    end else if (ctl[5] || (ctl[4] && !ctl[3])) begin
      m_next  = tgt;
      m_taken = 1;
    end else begin
      m_next = seq;
    end
  endtask

  task automatic model_commit;
    if (m_push) m_stack.push_back(8'(m_pc + 8'd1));
    if (m_pop) void'(m_stack.pop_back());
    if (m_bad) m_err = 1'b1;
    if (m_taken) m_cnt = m_cnt + 8'd1;
    m_pc = m_next;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic [5:0] ctl, input logic [3:0] nib, output logic [7:0] obs_pm);
    {jmp, jmp_nz, dont_jmp, call, ret, hold} = ctl;
    ir_nibble = nib;
    model_predict(ctl, nib);
    #2;
    obs_pm = pm_addr;
    check("pm_addr", 32'(pm_addr), 32'(m_next));
    @(posedge clk);
    #1;
    model_commit();
    check("pc", 32'(pc), 32'(m_pc));
    check("stack_depth", 32'(stack_depth), 32'(m_stack.size()));
    check("stack_err", 32'(stack_err), 32'(m_err));
    check("from_PS", 32'(from_PS), 32'(m_cnt));
  endtask

  task automatic do_reset;
    reset = 1'b1;
    {jmp, jmp_nz, dont_jmp, call, ret, hold} = C_IDLE;
    ir_nibble = 4'h0;
    #1;
    check("rst_pm_addr", 32'(pm_addr), 32'h00);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_depth", 32'(stack_depth), 32'h0);
    check("rst_err", 32'(stack_err), 32'h0);
    check("rst_from_PS", 32'(from_PS), 32'h00);
    @(posedge clk);
    #1;
    check("rst_pc_held", 32'(pc), 32'h00);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic advance_to(input logic [7:0] addr);
    logic [7:0] obs;
    for (int i = 0; i < 300 && pc != addr; i++) step(C_IDLE, 4'h0, obs);
    check("advance_to", 32'(pc), 32'(addr));
  endtask

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] obs;
    logic [5:0] rc;

    reset = 1'b1;
    {jmp, jmp_nz, dont_jmp, call, ret, hold} = C_IDLE;
    ir_nibble = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 20 idle clocks from reset
    for (int i = 0; i < 20; i++) begin
      check("idle_pc", 32'(pc), 32'(i));
      step(C_IDLE, 4'h0, obs);
      check("idle_pm", 32'(obs), 32'(i + 1));
    end
    check("idle_from_PS", 32'(from_PS), 32'h00);

    // Constant vector table from a fresh reset
    tbl[0]  = '{C_IDLE,          4'h0, 8'h01, 8'h01, 3'd0, 1'b0, 8'd0};
    tbl[1]  = '{C_JMP,           4'h5, 8'h05, 8'h05, 3'd0, 1'b0, 8'd1};
    tbl[2]  = '{C_JNZ | C_DONT,  4'h9, 8'h06, 8'h06, 3'd0, 1'b0, 8'd1};
    tbl[3]  = '{C_JNZ,           4'h9, 8'h09, 8'h09, 3'd0, 1'b0, 8'd2};
    tbl[4]  = '{C_CALL,          4'h2, 8'h02, 8'h02, 3'd1, 1'b0, 8'd3};
    tbl[5]  = '{C_JMP | C_HOLD,  4'hF, 8'h02, 8'h02, 3'd1, 1'b0, 8'd3};
    tbl[6]  = '{C_CALL,          4'hC, 8'h0C, 8'h0C, 3'd2, 1'b0, 8'd4};
    tbl[7]  = '{C_CALL | C_RET,  4'h0, 8'h03, 8'h03, 3'd1, 1'b0, 8'd5};
    tbl[8]  = '{C_RET,           4'h0, 8'h0A, 8'h0A, 3'd0, 1'b0, 8'd6};
    tbl[9]  = '{C_RET,           4'h0, 8'h0B, 8'h0B, 3'd0, 1'b1, 8'd6};
    tbl[10] = '{C_IDLE,          4'h0, 8'h0C, 8'h0C, 3'd0, 1'b1, 8'd6};
    tbl[11] = '{C_JMP | C_HOLD,  4'h0, 8'h0C, 8'h0C, 3'd0, 1'b1, 8'd6};
    tbl[12] = '{C_JMP,           4'h0, 8'h00, 8'h00, 3'd0, 1'b1, 8'd7};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ctl, tbl[i].nib, obs);
      check($sformatf("tbl%0d_pm", i), 32'(obs), 32'(tbl[i].pm));
      check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      check($sformatf("tbl%0d_depth", i), 32'(stack_depth), 32'(tbl[i].depth));
      check($sformatf("tbl%0d_err", i), 32'(stack_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d_cnt", i), 32'(from_PS), 32'(tbl[i].cnt));
    end

    // jmp within the page
    do_reset();
    advance_to(8'h37);
    step(C_JMP, 4'hA, obs);
    check("jmp_pm", 32'(obs), 32'h3A);
    check("jmp_pc", 32'(pc), 32'h3A);
    check("jmp_cnt", 32'(from_PS), 32'd1);

    // jmp_nz not taken, then taken
    advance_to(8'h50);
    step(C_JNZ | C_DONT, 4'h2, obs);
    check("jnz_fall_pc", 32'(pc), 32'h51);
    step(C_JNZ, 4'h2, obs);
    check("jnz_take_pc", 32'(pc), 32'h52);

    // call / ret round trip
    do_reset();
    advance_to(8'h20);
    step(C_CALL, 4'h8, obs);
    check("call_pc", 32'(pc), 32'h28);
    check("call_depth", 32'(stack_depth), 32'd1);
    step(C_RET, 4'h0, obs);
    check("ret_pc", 32'(pc), 32'h21);
    check("ret_depth", 32'(stack_depth), 32'd0);

    // Overflow then underflow
    for (int i = 0; i < 5; i++) step(C_CALL, 4'h0, obs);
    check("ovf_depth", 32'(stack_depth), 32'd4);
    check("ovf_err", 32'(stack_err), 32'd1);
    for (int i = 0; i < 5; i++) step(C_RET, 4'h0, obs);
    check("unf_pc", 32'(pc), 32'h23);
    check("unf_depth", 32'(stack_depth), 32'd0);

    // Hold during a jmp
    for (int i = 0; i < 3; i++) begin
      step(C_JMP | C_HOLD, 4'h7, obs);
      check("hold_pc", 32'(pc), 32'h23);
    end
    step(C_IDLE, 4'h0, obs);
    check("post_hold_pc", 32'(pc), 32'h24);

    // Wrap at the top of memory
    advance_to(8'hFF);
    step(C_IDLE, 4'h0, obs);
    check("wrap_pm", 32'(obs), 32'h00);
    check("wrap_pc", 32'(pc), 32'h00);

    // Asynchronous reset in the middle of a cycle
    step(C_CALL, 4'h6, obs);
    step(C_IDLE, 4'h0, obs);
    #2;
    reset = 1'b1;
    #1;
    check("async_pc", 32'(pc), 32'h00);
    check("async_pm", 32'(pm_addr), 32'h00);
    check("async_depth", 32'(stack_depth), 32'd0);
    check("async_cnt", 32'(from_PS), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("first_fetch_pc", 32'(pc), 32'h00);
    step(C_IDLE, 4'h0, obs);
    check("after_reset_pc", 32'(pc), 32'h01);

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      rc[5] = ($urandom_range(0, 6) == 0);
      rc[4] = ($urandom_range(0, 5) == 0);
      rc[3] = $urandom_range(0, 1) != 0;
      rc[2] = ($urandom_range(0, 5) == 0);
      rc[1] = ($urandom_range(0, 5) == 0);
      rc[0] = ($urandom_range(0, 9) == 0);
      step(rc, 4'($urandom_range(0, 15)), obs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
